// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port round-robin memory arbiter.
// FSM states and requester index constants.
package mem_arb_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int NREQ = 2;
   localparam int REQ0 = 0;
   localparam int REQ1 = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant generator; prio names the requester that wins a tie.
// Purely combinational, so the grant follows req in the same cycle.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic            enable,
   input  logic            prio,
   output logic [NREQ-1:0] gnt
);

   always_comb begin
      gnt = '0;
      if (enable) begin
         if (&req) gnt[prio] = 1'b1;
         else      gnt       = req;
      end
   end

endmodule

// File: rtl/mem_rr_arbiter.sv
// DEPTH x WIDTH register memory shared by two requesters under round-robin arbitration.
// After reset the array is cleared one entry per cycle before any grant is issued.
module mem_rr_arbiter
   import mem_arb_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int DEPTH  = 3,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [WIDTH-1:0]  wdata0,
   input  logic [WIDTH-1:0]  wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [WIDTH-1:0]  rdata0,
   output logic [WIDTH-1:0]  rdata1,
   output logic              init_done,
   output logic              err
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   logic [NREQ-1:0]             req_v, we_v, gnt_v, rvalid_v;
   logic [NREQ-1:0][ADDR_W-1:0] addr_v;
   logic [NREQ-1:0][WIDTH-1:0]  wdata_v, rdata_v;

   assign req_v   = {req1, req0};
   assign we_v    = {we1, we0};
   assign addr_v  = {addr1, addr0};
   assign wdata_v = {wdata1, wdata0};
   assign gnt0    = gnt_v[REQ0];
   assign gnt1    = gnt_v[REQ1];
   assign rvalid0 = rvalid_v[REQ0];
   assign rvalid1 = rvalid_v[REQ1];
   assign rdata0  = rdata_v[REQ0];
   assign rdata1  = rdata_v[REQ1];

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] ptr;
   logic              prio;
   logic              arb_en, init_wr;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_INIT;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_INIT: if (ptr == LAST) state_nxt = ST_RUN;
         ST_RUN:  state_nxt = ST_RUN;
      endcase
   end

   always_comb begin
      arb_en  = 1'b0;
      init_wr = 1'b0;
      case (state)
         ST_INIT: init_wr = 1'b1;
         ST_RUN:  arb_en  = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr       <= '0;
         init_done <= 1'b0;
      end else if (init_wr) begin
         ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
         if (ptr == LAST) init_done <= 1'b1;
      end
   end

   rr_arb2 u_arb (
      .req    (req_v),
      .enable (arb_en),
      .prio   (prio),
      .gnt    (gnt_v)
   );

   // Whoever was just served loses the tie next time, even without contention.
   always_ff @(posedge clk) begin
      if (!rst_n)      prio <= 1'(REQ0);
      else if (|gnt_v) prio <= gnt_v[REQ0];
   end

   // At most one grant per cycle, so a single access port suffices.
   logic              g_any, g_sel, g_we, g_ok;
   logic [ADDR_W-1:0] g_addr;
   logic [WIDTH-1:0]  g_wdata, rd_word;

   assign g_any   = |gnt_v;
   assign g_sel   = gnt_v[REQ1];
   assign g_we    = we_v[g_sel];
   assign g_addr  = addr_v[g_sel];
   assign g_wdata = wdata_v[g_sel];
   assign g_ok    = int'(g_addr) < DEPTH;

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (init_wr)                  mem[ptr]    <= '0;
         else if (g_any && g_we && g_ok) mem[g_addr] <= g_wdata;
      end
   end

   always_comb begin
      rd_word = '0;
      if (g_ok) rd_word = mem[g_addr];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rvalid_v <= '0;
         rdata_v  <= '0;
         err      <= 1'b0;
      end else begin
         err <= g_any && !g_ok;
         for (int i = 0; i < NREQ; i++) begin
            rvalid_v[i] <= gnt_v[i] && !we_v[i];
            if (gnt_v[i] && !we_v[i]) rdata_v[i] <= rd_word;
         end
      end
   end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter: init clear, read-after-write, contention,
// out-of-range accesses, back-to-back writes and reset mid-read.
module tb_mem_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0, req1, we0, we1;
   logic [1:0] addr0, addr1;
   logic [3:0] wdata0, wdata1;
   logic       gnt0, gnt1, rvalid0, rvalid1, init_done, err;
   logic [3:0] rdata0, rdata1;

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_rr_arbiter #(.WIDTH(4), .DEPTH(3), .ADDR_W(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0      (req0),
      .req1      (req1),
      .we0       (we0),
      .we1       (we1),
      .addr0     (addr0),
      .addr1     (addr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .rvalid0   (rvalid0),
      .rvalid1   (rvalid1),
      .rdata0    (rdata0),
      .rdata1    (rdata1),
      .init_done (init_done),
      .err       (err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock and land on the falling edge for sampling/driving.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      cyc(); cyc();
      chk("rst_init_done", init_done, 0);
      chk("rst_rvalid0", rvalid0, 0);
      chk("rst_rvalid1", rvalid1, 0);
      chk("rst_err", err, 0);
      chk("rst_rdata0", rdata0, 0);

      // INIT: DEPTH cycles with no grant even though req0 is up
      req0 = 1; we0 = 0; addr0 = 0;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("init_done_c%0d", i), init_done, 0);
         chk($sformatf("init_gnt0_c%0d", i), gnt0, 0);
         cyc();
      end
      chk("init_done_c3", init_done, 1);

      // entries cleared by INIT
      for (int i = 0; i < 3; i++) begin
         addr0 = 2'(i);
         #1 chk($sformatf("clr_gnt0_a%0d", i), gnt0, 1);
         cyc();
         chk($sformatf("clr_rvalid0_a%0d", i), rvalid0, 1);
         chk($sformatf("clr_rdata0_a%0d", i), rdata0, 0);
      end

      // write then read same address back-to-back
      we0 = 1; addr0 = 1; wdata0 = 4'hA;
      #1 chk("wr_gnt0", gnt0, 1);
      cyc();
      chk("wr_no_rvalid0", rvalid0, 0);
      we0 = 0;
      #1 chk("rd_gnt0", gnt0, 1);
      cyc();
      chk("raw_rvalid0", rvalid0, 1);
      chk("raw_rdata0", rdata0, 4'hA);
      req0 = 0;

      // req1 alone reads addr 1; priority passes back to requester 0
      req1 = 1; we1 = 0; addr1 = 1;
      #1 chk("solo_gnt1", gnt1, 1);
      chk("solo_gnt0", gnt0, 0);
      cyc();
      chk("solo_rvalid1", rvalid1, 1);
      chk("solo_rdata1", rdata1, 4'hA);
      chk("solo_rvalid0", rvalid0, 0);

      // contention: both read addr 0, grants alternate 0,1,0,1
      req0 = 1; we0 = 0; addr0 = 0; addr1 = 0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("cont_gnt0_%0d", k), gnt0, (k % 2) == 0);
         chk($sformatf("cont_gnt1_%0d", k), gnt1, (k % 2) == 1);
         cyc();
         chk($sformatf("cont_rvalid0_%0d", k), rvalid0, (k % 2) == 0);
         chk($sformatf("cont_rvalid1_%0d", k), rvalid1, (k % 2) == 1);
      end
      chk("cont_rdata1", rdata1, 0);
      req0 = 0;

      // refresh rdata1 to a nonzero value so the out-of-range read is visible
      addr1 = 1;
      cyc();
      chk("pre_rdata1", rdata1, 4'hA);

      // out-of-range write is dropped and flagged
      we1 = 1; addr1 = 3; wdata1 = 4'hF;
      #1 chk("oor_wr_gnt1", gnt1, 1);
      cyc();
      chk("oor_wr_err", err, 1);
      chk("oor_wr_rvalid1", rvalid1, 0);
      we1 = 0;
      #1 chk("oor_rd_gnt1", gnt1, 1);
      cyc();
      chk("oor_rd_rvalid1", rvalid1, 1);
      chk("oor_rd_rdata1", rdata1, 0);
      chk("oor_rd_err", err, 1);
      req1 = 0;

      // array untouched: 0, A, 0
      req0 = 1; we0 = 0;
      for (int i = 0; i < 3; i++) begin
         addr0 = 2'(i);
         cyc();
         chk($sformatf("post_oor_rdata0_a%0d", i), rdata0, (i == 1) ? 4'hA : 4'h0);
         chk($sformatf("post_oor_err_a%0d", i), err, 0);
      end
      req0 = 0;

      // single requester writing every cycle
      req1 = 1; we1 = 1; addr1 = 2;
      for (int d = 1; d <= 5; d++) begin
         wdata1 = 4'(d);
         #1 chk($sformatf("b2b_gnt1_%0d", d), gnt1, 1);
         cyc();
      end
      we1 = 0;
      cyc();
      chk("b2b_rvalid1", rvalid1, 1);
      chk("b2b_rdata1", rdata1, 5);
      req1 = 0;

      // reset lands on the edge of a granted read
      req0 = 1; we0 = 0; addr0 = 1;
      #1 chk("mid_gnt0", gnt0, 1);
      rst_n = 1'b0;
      cyc();
      chk("mid_rvalid0", rvalid0, 0);
      chk("mid_init_done", init_done, 0);
      rst_n = 1'b1;
      req0 = 0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("reinit_done_c%0d", i), init_done, 0);
         cyc();
      end
      chk("reinit_done", init_done, 1);
      req0 = 1; addr0 = 1;
      cyc();
      chk("reinit_rdata0_a1", rdata0, 0);
      chk("reinit_rvalid0_a1", rvalid0, 1);
      addr0 = 2;
      cyc();
      chk("reinit_rdata0_a2", rdata0, 0);
      req0 = 0;
      cyc();
      chk("idle_rvalid0", rvalid0, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
